forwarding_hazard_unit: RTL and testbench

FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

---
 rtl/hazard_pkg.sv | 13 +
 rtl/fwd_select.sv | 34 +++
 rtl/forwarding_hazard_unit.sv | 103 ++++++++++
 tb/tb_forwarding_hazard_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package hazard_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    function automatic int fsel_width(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand source select for one EX source: youngest matching producer wins.
module fwd_select #(
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1,
    parameter int FSEL_W   = 2
) (
    input  logic [4:0]               rs,
    input  logic [NUM_FWD-1:0][4:0]  stage_rd,
    input  logic [NUM_FWD-1:0]       stage_regwrite,
    input  logic [NUM_FWD-1:0]       stage_is_load,
    output logic [FSEL_W-1:0]        sel,
    output logic                     load_pending
);

    logic hit;

    // Once the youngest match is found, older stages are ignored even if
    // that match turns out to be a load whose data is not ready yet.
    always_comb begin
        sel          = '0;
        load_pending = 1'b0;
        hit          = 1'b0;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (!hit && rs != 5'd0 && stage_regwrite[k] && stage_rd[k] == rs) begin
                hit = 1'b1;
                if (stage_is_load[k] && k < LOAD_LAT)
                    load_pending = 1'b1;
                else
                    sel = FSEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding select plus load-use stall sequencer with stall counter.
// state | meaning
// IDLE  | no stall in progress; stall follows the load-use hazard directly
// STALL | holding the pipeline for the remaining load latency cycles
module forwarding_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1,
    localparam int FSEL_W  = fsel_width(NUM_FWD)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic [NUM_SRC-1:0][4:0]        id_rs,
    input  logic [NUM_SRC-1:0][4:0]        ex_rs,
    input  logic [4:0]                     ex_rd,
    input  logic                           ex_regwrite,
    input  logic                           ex_is_load,
    input  logic [NUM_FWD-1:0][4:0]        stage_rd,
    input  logic [NUM_FWD-1:0]             stage_regwrite,
    input  logic [NUM_FWD-1:0]             stage_is_load,
    input  logic                           flush,
    output logic [NUM_SRC-1:0][FSEL_W-1:0] forward_sel,
    output logic                           stall,
    output logic                           bubble,
    output logic                           fwd_err,
    output logic [31:0]                    stall_cycles
);

    hz_state_t          state;
    logic [2:0]         cnt;
    logic [NUM_SRC-1:0] src_err;
    logic               id_match;
    logic               hazard;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_select #(
            .NUM_FWD  (NUM_FWD),
            .LOAD_LAT (LOAD_LAT),
            .FSEL_W   (FSEL_W)
        ) u_fwd_select (
            .rs             (ex_rs[i]),
            .stage_rd       (stage_rd),
            .stage_regwrite (stage_regwrite),
            .stage_is_load  (stage_is_load),
            .sel            (forward_sel[i]),
            .load_pending   (src_err[i])
        );
    end

    assign fwd_err = |src_err;

    always_comb begin
        id_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (id_rs[i] == ex_rd)
                id_match = 1'b1;
    end

    assign hazard = id_valid & ex_is_load & ex_regwrite & (ex_rd != 5'd0) & id_match;

    // The first stall cycle comes straight from the hazard so the load-use
    // pair is caught in the same cycle; STALL covers the remaining cycles.
    assign stall  = !rst && !flush && (state == STALL || hazard);
    assign bubble = stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            stall_cycles <= 32'd0;
        end else begin
            if (stall && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;

            if (flush) begin
                state <= IDLE;
                cnt   <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (hazard && LOAD_LAT > 1) begin
                            state <= STALL;
                            cnt   <= 3'(LOAD_LAT - 1);
                        end
                    end
                    STALL: begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1)
                            state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench: default-parameter instance and a LOAD_LAT=3 / NUM_FWD=4 instance.
module tb_forwarding_hazard_unit;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [1:0][4:0] id_rs;
    logic [1:0][4:0] ex_rs;
    logic [4:0]      ex_rd;
    logic            ex_regwrite;
    logic            ex_is_load;
    logic            flush;

    logic [1:0][4:0] stage_rd_a;
    logic [1:0]      stage_regwrite_a;
    logic [1:0]      stage_is_load_a;
    logic [1:0][1:0] fsel_a;
    logic            stall_a, bubble_a, fwd_err_a;
    logic [31:0]     stall_cycles_a;

    logic [3:0][4:0] stage_rd_b;
    logic [3:0]      stage_regwrite_b;
    logic [3:0]      stage_is_load_b;
    logic [1:0][2:0] fsel_b;
    logic            stall_b, bubble_b, fwd_err_b;
    logic [31:0]     stall_cycles_b;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forwarding_hazard_unit u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .ex_rs          (ex_rs),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_is_load     (ex_is_load),
        .stage_rd       (stage_rd_a),
        .stage_regwrite (stage_regwrite_a),
        .stage_is_load  (stage_is_load_a),
        .flush          (flush),
        .forward_sel    (fsel_a),
        .stall          (stall_a),
        .bubble         (bubble_a),
        .fwd_err        (fwd_err_a),
        .stall_cycles   (stall_cycles_a)
    );

    forwarding_hazard_unit #(
        .NUM_SRC  (2),
        .NUM_FWD  (4),
        .LOAD_LAT (3)
    ) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .ex_rs          (ex_rs),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_is_load     (ex_is_load),
        .stage_rd       (stage_rd_b),
        .stage_regwrite (stage_regwrite_b),
        .stage_is_load  (stage_is_load_b),
        .flush          (flush),
        .forward_sel    (fsel_b),
        .stall          (stall_b),
        .bubble         (bubble_b),
        .fwd_err        (fwd_err_b),
        .stall_cycles   (stall_cycles_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_hazard(input logic on);
        id_valid    = on;
        id_rs[0]    = on ? 5'd9 : 5'd0;
        id_rs[1]    = 5'd0;
        ex_rd       = on ? 5'd9 : 5'd0;
        ex_regwrite = on;
        ex_is_load  = on;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        ex_rs = '0;
        stage_rd_a = '0; stage_regwrite_a = '0; stage_is_load_a = '0;
        stage_rd_b = '0; stage_regwrite_b = '0; stage_is_load_b = '0;
        set_hazard(1'b1);
        #12;
        check("rst_stall_a", 32'(stall_a), 32'd0);
        check("rst_bubble_a", 32'(bubble_a), 32'd0);
        check("rst_stall_b", 32'(stall_b), 32'd0);
        check("rst_cnt_b", stall_cycles_b, 32'd0);
        set_hazard(1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Forwarding, default instance
        next_cycle();
        stage_rd_a[0] = 5'd5; stage_rd_a[1] = 5'd5;
        stage_regwrite_a = 2'b11; stage_is_load_a = 2'b00;
        ex_rs[0] = 5'd5; ex_rs[1] = 5'd0;
        @(negedge clk);
        check("youngest_wins", 32'(fsel_a[0]), 32'd1);
        check("rs0_zero_sel", 32'(fsel_a[1]), 32'd0);
        check("alu_no_err", 32'(fwd_err_a), 32'd0);

        next_cycle();
        stage_rd_a[0] = 5'd5; stage_rd_a[1] = 5'd6;
        ex_rs[0] = 5'd6; ex_rs[1] = 5'd5;
        @(negedge clk);
        check("older_stage_sel", 32'(fsel_a[0]), 32'd2);
        check("young_stage_sel", 32'(fsel_a[1]), 32'd1);

        next_cycle();
        stage_rd_a[0] = 5'd7; stage_rd_a[1] = 5'd7;
        stage_is_load_a = 2'b01;
        ex_rs[0] = 5'd3; ex_rs[1] = 5'd7;
        @(negedge clk);
        check("load_not_ready_sel", 32'(fsel_a[1]), 32'd0);
        check("load_not_ready_err", 32'(fwd_err_a), 32'd1);
        check("no_match_sel", 32'(fsel_a[0]), 32'd0);

        next_cycle();
        stage_rd_a[0] = 5'd0; stage_rd_a[1] = 5'd0;
        stage_is_load_a = 2'b00;
        ex_rs[0] = 5'd0; ex_rs[1] = 5'd0;
        @(negedge clk);
        check("x0_sel0", 32'(fsel_a[0]), 32'd0);
        check("x0_sel1", 32'(fsel_a[1]), 32'd0);

        next_cycle();
        stage_rd_a[0] = 5'd8; stage_rd_a[1] = 5'd8;
        stage_regwrite_a = 2'b00;
        ex_rs[0] = 5'd8;
        @(negedge clk);
        check("no_regwrite_sel", 32'(fsel_a[0]), 32'd0);

        // Forwarding, LOAD_LAT=3 instance
        next_cycle();
        stage_rd_b[0] = 5'd9; stage_rd_b[1] = 5'd0; stage_rd_b[2] = 5'd0; stage_rd_b[3] = 5'd9;
        stage_regwrite_b = 4'b1111; stage_is_load_b = 4'b0001;
        ex_rs[0] = 5'd9; ex_rs[1] = 5'd0;
        @(negedge clk);
        check("b_young_load_sel", 32'(fsel_b[0]), 32'd0);
        check("b_young_load_err", 32'(fwd_err_b), 32'd1);

        next_cycle();
        stage_rd_b[0] = 5'd0; stage_rd_b[3] = 5'd4;
        stage_is_load_b = 4'b1000;
        ex_rs[0] = 5'd4;
        @(negedge clk);
        check("b_old_load_ready_sel", 32'(fsel_b[0]), 32'd4);
        check("b_old_load_ready_err", 32'(fwd_err_b), 32'd0);

        next_cycle();
        stage_rd_b[2] = 5'd4;
        stage_is_load_b = 4'b1100;
        ex_rs[1] = 5'd4; ex_rs[0] = 5'd0;
        @(negedge clk);
        check("b_k2_load_sel", 32'(fsel_b[1]), 32'd0);
        check("b_k2_load_err", 32'(fwd_err_b), 32'd1);
        stage_rd_b = '0; stage_regwrite_b = '0; stage_is_load_b = '0;
        ex_rs = '0;

        // Load-use stall, exactly 3 cycles on instance b
        next_cycle();
        set_hazard(1'b1);
        @(negedge clk);
        check("ls_c1_stall_b", 32'(stall_b), 32'd1);
        check("ls_c1_bubble_b", 32'(bubble_b), 32'd1);
        check("ls_c1_stall_a", 32'(stall_a), 32'd1);
        next_cycle();
        set_hazard(1'b0);
        @(negedge clk);
        check("ls_c2_stall_b", 32'(stall_b), 32'd1);
        check("ls_c2_bubble_b", 32'(bubble_b), 32'd1);
        check("ls_c2_stall_a", 32'(stall_a), 32'd0);
        next_cycle();
        @(negedge clk);
        check("ls_c3_stall_b", 32'(stall_b), 32'd1);
        next_cycle();
        @(negedge clk);
        check("ls_c4_stall_b", 32'(stall_b), 32'd0);
        check("ls_c4_bubble_b", 32'(bubble_b), 32'd0);
        check("ls_cnt_b", stall_cycles_b, 32'd3);
        check("ls_cnt_a", stall_cycles_a, 32'd1);

        // Flush on the second stall cycle
        next_cycle();
        set_hazard(1'b1);
        @(negedge clk);
        check("fl_c1_stall_b", 32'(stall_b), 32'd1);
        next_cycle();
        set_hazard(1'b0);
        flush = 1'b1;
        @(negedge clk);
        check("fl_c2_stall_b", 32'(stall_b), 32'd0);
        check("fl_c2_bubble_b", 32'(bubble_b), 32'd0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("fl_c3_idle_b", 32'(stall_b), 32'd0);
        check("fl_cnt_b", stall_cycles_b, 32'd4);

        // x0 load and non-writing load do not stall
        next_cycle();
        id_valid = 1'b1; id_rs = '0; ex_rd = 5'd0; ex_regwrite = 1'b1; ex_is_load = 1'b1;
        @(negedge clk);
        check("x0_load_stall_a", 32'(stall_a), 32'd0);
        check("x0_load_stall_b", 32'(stall_b), 32'd0);
        next_cycle();
        id_rs[1] = 5'd9; ex_rd = 5'd9; ex_regwrite = 1'b0;
        @(negedge clk);
        check("nowr_load_stall_b", 32'(stall_b), 32'd0);
        next_cycle();
        set_hazard(1'b0);

        // Reset asserted mid-stall
        next_cycle();
        set_hazard(1'b1);
        next_cycle();
        set_hazard(1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_stall_b", 32'(stall_b), 32'd0);
        check("rst_mid_bubble_b", 32'(bubble_b), 32'd0);
        check("rst_mid_cnt_b", stall_cycles_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        check("post_rst_idle_b", 32'(stall_b), 32'd0);

        // Back-to-back hazards: two full sequences with no gap
        next_cycle();
        set_hazard(1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("b2b_c%0d_stall_b", c), 32'(stall_b), 32'd1);
            check($sformatf("b2b_c%0d_stall_a", c), 32'(stall_a), 32'd1);
            next_cycle();
        end
        set_hazard(1'b0);
        @(negedge clk);
        check("b2b_end_stall_b", 32'(stall_b), 32'd0);
        check("b2b_cnt_b", stall_cycles_b, 32'd6);
        check("b2b_cnt_a", stall_cycles_a, 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
